// File: rtl/demorgan_sweep.sv
// demorgan_sweep: self-running exhaustive De Morgan checker.
// Sweeps every {A,B} operand pair of WIDTH bits, registers the seven derived
// bitwise terms for each pair as a result row, checks both De Morgan
// identities on every row and counts the rows that violate one.
// Optional build macro DEMORGAN_SWEEP_FAULT_EN adds input fault_inject, which
// inverts bit 0 of res_nanorb at its register input so the checker can be
// shown to detect a fault.
module demorgan_sweep #(
  parameter int unsigned WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
`ifdef DEMORGAN_SWEEP_FAULT_EN
  input  logic                 fault_inject,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 vec_valid,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 res_valid,
  output logic [WIDTH-1:0]     res_na,
  output logic [WIDTH-1:0]     res_nb,
  output logic [WIDTH-1:0]     res_nanb,
  output logic [WIDTH-1:0]     res_and,
  output logic [WIDTH-1:0]     res_nand,
  output logic [WIDTH-1:0]     res_nor,
  output logic [WIDTH-1:0]     res_nanorb,
  output logic                 mismatch,
  output logic [2*WIDTH:0]     err_count
);

  // Index width covers both operands; the counter has room for all N rows.
  localparam int unsigned IW = 2 * WIDTH;
  localparam int unsigned CW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic            busy_q;
  logic            done_q;
  logic            vec_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic            res_valid_q;
  logic [WIDTH-1:0] na_q, nb_q, nanb_q, and_q, nand_q, nor_q, nanorb_q;
  logic            mismatch_q;
  logic [CW-1:0]   err_count_q;

  logic [WIDTH-1:0] na_d, nb_d, nanb_d, and_d, nand_d, nor_d, nanorb_d;
  logic            mis_d;
  logic            start_accept_c;

  // A start is honoured only from IDLE; starts in any other state are dropped.
  assign start_accept_c = (state_q == ST_IDLE) && start;

  // Sweep sequencer. Vector 0 is presented on the start edge itself, so
  // idx_q always holds the index of the next vector to present.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vec_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_RUN;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= IW'(1);
            busy_q      <= 1'b1;
            vec_valid_q <= 1'b1;
          end
        end
        ST_RUN: begin
          a_q <= idx_q[IW-1:WIDTH];
          b_q <= idx_q[WIDTH-1:0];
          // Stop on the last index rather than letting idx_q wrap.
          if (idx_q == {IW{1'b1}}) begin
            state_q <= ST_DRAIN;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_DRAIN: begin
          vec_valid_q <= 1'b0;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          idx_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Derived terms for the vector currently on a_out/b_out.
  always_comb begin
    na_d     = ~a_q;
    nb_d     = ~b_q;
    nanb_d   = ~a_q & ~b_q;
    and_d    = a_q & b_q;
    nand_d   = ~(a_q & b_q);
    nor_d    = ~(a_q | b_q);
    nanorb_d = ~a_q | ~b_q;
`ifdef DEMORGAN_SWEEP_FAULT_EN
    nanorb_d[0] = nanorb_d[0] ^ fault_inject;
`endif
    mis_d    = (nand_d != nanorb_d) || (nor_d != nanb_d);
  end

  // Result row register; the identity check is registered alongside so the
  // mismatch flag lines up with the row it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      na_q        <= '0;
      nb_q        <= '0;
      nanb_q      <= '0;
      and_q       <= '0;
      nand_q      <= '0;
      nor_q       <= '0;
      nanorb_q    <= '0;
    end else begin
      res_valid_q <= vec_valid_q;
      mismatch_q  <= vec_valid_q && mis_d;
      if (vec_valid_q) begin
        na_q     <= na_d;
        nb_q     <= nb_d;
        nanb_q   <= nanb_d;
        and_q    <= and_d;
        nand_q   <= nand_d;
        nor_q    <= nor_d;
        nanorb_q <= nanorb_d;
      end
    end
  end

  // Mismatch row counter; cleared by an accepted start, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= '0;
    end else if (start_accept_c) begin
      err_count_q <= '0;
    end else if (mismatch_q) begin
      err_count_q <= err_count_q + CW'(1);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign vec_valid  = vec_valid_q;
  assign a_out      = a_q;
  assign b_out      = b_q;
  assign res_valid  = res_valid_q;
  assign res_na     = na_q;
  assign res_nb     = nb_q;
  assign res_nanb   = nanb_q;
  assign res_and    = and_q;
  assign res_nand   = nand_q;
  assign res_nor    = nor_q;
  assign res_nanorb = nanorb_q;
  assign mismatch   = mismatch_q;
  assign err_count  = err_count_q;

endmodule

// File: doc/demorgan_sweep.md
# demorgan_sweep

Parametrised, self-running exhaustive De Morgan checker. Internally sweeps every combination of two WIDTH-bit operands and presents each vector plus the seven derived bitwise terms as a registered truth-table row. It checks both De Morgan identities on every row and accumulates a mismatch count. It replaces the hand-stepped 1-bit truth-table bench as the regression source for the bitwise logic path.

## Interface

Parameters:
- WIDTH, 2, operand width in bits; legal range 1..8; vector count N = 2^(2*WIDTH)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  begin a sweep; sampled only in IDLE
- busy  out  1  high from the start edge through the last result row
- done  out  1  one-cycle pulse after the last row
- vec_valid  out  1  a_out/b_out hold a new vector
- a_out  out  WIDTH  operand A of the current vector
- b_out  out  WIDTH  operand B of the current vector
- res_valid  out  1  res_* hold the terms for the previous vector
- res_na, res_nb  out  WIDTH each  ~A, ~B
- res_nanb  out  WIDTH  ~A & ~B
- res_and  out  WIDTH  A & B
- res_nand  out  WIDTH  ~(A & B)
- res_nor  out  WIDTH  ~(A | B)
- res_nanorb  out  WIDTH  ~A | ~B
- mismatch  out  1  current result row violates an identity
- err_count  out  2*WIDTH+1  rows with mismatch since last start

## Operation

- State machine IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 at an edge enters RUN and does the following on that edge:
  - load vector index idx=0
  - clear err_count
  - set busy=1, vec_valid=1
- RUN: each edge registers a_out=idx[2W-1:W], b_out=idx[W-1:0], then idx+1. After presenting idx=N-1, go to DRAIN and drop vec_valid. idx never wraps inside a sweep.
- Stage 2 registers all res_* from a_out/b_out every cycle that vec_valid=1, and sets res_valid.
- mismatch = res_valid & ((res_nand != res_nanorb) | (res_nor != res_nanb)). err_count increments on each mismatch cycle. err_count cannot overflow, since it has room for N.
- DRAIN: last row is shown (res_valid=1), then go to DONE.
- DONE: done=1, busy=0, res_valid=0 for one cycle, then IDLE.
- err_count holds its value until the next start or reset.
- start while busy is ignored. start held high in IDLE/DONE only triggers from IDLE.
- reset mid-sweep: next edge forces IDLE and clears all outputs. No done pulse.

## Timing

- Reset values: all outputs 0, state IDLE, idx 0.
- Start edge E0: vector k appears at E0+k, for k=0..N-1.
- Result row k appears at E0+k+1, with mismatch valid in the same cycle.
- err_count includes row k at E0+k+2.
- done pulses at E0+N+1. busy is high E0..E0+N, for N+1 cycles total.
- Earliest next start is accepted at E0+N+2.

## Configuration

- DEMORGAN_SWEEP_FAULT_EN defined:
  - adds input port fault_inject (1 bit)
  - while fault_inject=1, bit 0 of res_nanorb is inverted at its register input
  - used to prove the checker can detect a fault
- Undefined: no port is added and res_nanorb is always the exact value.

## Test plan

- WIDTH=1, reset, start pulse: rows in order (A,B) = 00, 01, 10, 11.
  - row 10 must give na=0, nb=1, nanb=0, and=0, nand=1, nor=0, nanorb=1
  - done at E0+5, err_count=0
- WIDTH=2, start: 16 vectors with a_out/b_out counting 0..15 as {A,B}; busy high 17 cycles; done at E0+17; err_count=0.
- WIDTH=2, FAULT_EN, fault_inject=1 throughout: mismatch on all 16 rows; err_count=16 at E0+18.
- WIDTH=2, reset asserted at E0+6: next cycle busy=0, vec_valid=0, res_valid=0, err_count=0, and no done. A fresh start then completes normally.
- Start re-pulsed at E0+3 and start held high through DONE: the sweep is unaffected, a second sweep begins at E0+N+2, and err_count restarts at 0.
